// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolver: compares forwarded operands, registers the outcome,
// and maintains a 2-bit saturating branch history table read by fetch.
module branch_resolve_unit #(
  parameter int WIDTH       = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int SIGNED_CMP  = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             stall,
  input  logic [31:0]      IR,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [31:0]      pc_id,
  input  logic             pred_taken_in,
  input  logic [31:0]      lookup_pc,
  output logic             lookup_taken,
  output logic             branchYes,
  output logic             is_branch,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX = $clog2(BHT_ENTRIES);

  logic [5:0]             opcode;
  logic [IDX-1:0]         upd_idx;
  logic [IDX-1:0]         lk_idx;
  logic signed [WIDTH:0]  a_ext;
  logic signed [WIDTH:0]  b_ext;
  logic                   is_br_op;
  logic                   taken;
  logic                   br_valid;
  logic                   mispredict_d;

  logic                   branch_yes_q;
  logic                   is_branch_q;
  logic                   mispredict_q;
  logic [CNT_W-1:0]       branch_cnt_q;
  logic [CNT_W-1:0]       mispredict_cnt_q;
  logic [1:0]             bht_q [BHT_ENTRIES];

  logic                   unused_bits;

  function automatic logic [1:0] bht_next(input logic [1:0] cur, input logic t);
    if (t) return (cur == 2'b11) ? cur : cur + 2'b01;
    else   return (cur == 2'b00) ? cur : cur - 2'b01;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] cur);
    return (&cur) ? cur : cur + 1'b1;
  endfunction

  assign opcode  = IR[31:26];
  assign upd_idx = pc_id[IDX+1:2];
  assign lk_idx  = lookup_pc[IDX+1:2];

  // One extra bit makes a single signed compare serve both signed and unsigned modes.
  assign a_ext = {(SIGNED_CMP != 0) & In1[WIDTH-1], In1};
  assign b_ext = {(SIGNED_CMP != 0) & In2[WIDTH-1], In2};

  always_comb begin
    is_br_op = 1'b1;
    taken    = 1'b0;
    case (opcode)
      6'h08:   taken = (In1 == In2);
      6'h09:   taken = (In1 != In2);
      6'h0A:   taken = (a_ext >= b_ext);
      6'h0B:   taken = (a_ext >  b_ext);
      6'h0C:   taken = (a_ext <= b_ext);
      6'h0D:   taken = (a_ext <  b_ext);
      default: is_br_op = 1'b0;
    endcase
  end

  assign br_valid     = valid_in & is_br_op;
  assign mispredict_d = br_valid & (taken != pred_taken_in);

  // Read-before-write: the lookup sees the table as it stands before this edge.
  assign lookup_taken = bht_q[lk_idx][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_yes_q     <= 1'b0;
      is_branch_q      <= 1'b0;
      mispredict_q     <= 1'b0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (!stall) begin
      branch_yes_q <= br_valid & taken;
      is_branch_q  <= br_valid;
      mispredict_q <= mispredict_d;
      if (br_valid) begin
        bht_q[upd_idx] <= bht_next(bht_q[upd_idx], taken);
        branch_cnt_q   <= cnt_sat_inc(branch_cnt_q);
        if (mispredict_d) mispredict_cnt_q <= cnt_sat_inc(mispredict_cnt_q);
      end
    end
  end

  assign branchYes        = branch_yes_q;
  assign is_branch        = is_branch_q;
  assign mispredict       = mispredict_q;
  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispredict_cnt_q;

  assign unused_bits = ^{IR[25:0], pc_id[31:IDX+2], pc_id[1:0],
                         lookup_pc[31:IDX+2], lookup_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: signed and unsigned instances driven in lockstep
// and compared every cycle against an arithmetic reference model.
module tb_branch_resolve_unit;

  localparam int CW = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, stall, pred_taken_in;
  logic [31:0] IR, In1, In2, pc_id, lookup_pc;

  logic          o_lt [2];
  logic          o_by [2];
  logic          o_ib [2];
  logic          o_mp [2];
  logic [CW-1:0] o_bc [2];
  logic [CW-1:0] o_mc [2];

  int m_bht [2][16];
  int m_by [2], m_ib [2], m_mp [2], m_bc [2], m_mc [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.WIDTH(32), .BHT_ENTRIES(16), .SIGNED_CMP(1), .CNT_W(CW)) dut_s (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .IR(IR), .In1(In1), .In2(In2),
    .pc_id(pc_id), .pred_taken_in(pred_taken_in), .lookup_pc(lookup_pc),
    .lookup_taken(o_lt[0]), .branchYes(o_by[0]), .is_branch(o_ib[0]), .mispredict(o_mp[0]),
    .branch_count(o_bc[0]), .mispredict_count(o_mc[0]));

  branch_resolve_unit #(.WIDTH(32), .BHT_ENTRIES(16), .SIGNED_CMP(0), .CNT_W(CW)) dut_u (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .IR(IR), .In1(In1), .In2(In2),
    .pc_id(pc_id), .pred_taken_in(pred_taken_in), .lookup_pc(lookup_pc),
    .lookup_taken(o_lt[1]), .branchYes(o_by[1]), .is_branch(o_ib[1]), .mispredict(o_mp[1]),
    .branch_count(o_bc[1]), .mispredict_count(o_mc[1]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_taken(input bit sgn, input logic [5:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    if (sgn) begin x = longint'($signed(a)); y = longint'($signed(b)); end
    else     begin x = a; y = b; end
    case (op)
      6'h08: return x == y;
      6'h09: return x != y;
      6'h0A: return x >= y;
      6'h0B: return x >  y;
      6'h0C: return x <= y;
      6'h0D: return x <  y;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) m_bht[k][i] = 1;
      m_by[k] = 0; m_ib[k] = 0; m_mp[k] = 0; m_bc[k] = 0; m_mc[k] = 0;
    end
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, k == 0 ? "_s_branchYes" : "_u_branchYes"}, 32'(o_by[k]), 32'(m_by[k]));
      check({tag, k == 0 ? "_s_is_branch" : "_u_is_branch"}, 32'(o_ib[k]), 32'(m_ib[k]));
      check({tag, k == 0 ? "_s_mispredict" : "_u_mispredict"}, 32'(o_mp[k]), 32'(m_mp[k]));
      check({tag, k == 0 ? "_s_branch_count" : "_u_branch_count"}, 32'(o_bc[k]), 32'(m_bc[k]));
      check({tag, k == 0 ? "_s_mispredict_count" : "_u_mispredict_count"}, 32'(o_mc[k]), 32'(m_mc[k]));
    end
  endtask

  task automatic check_lookup(input string tag, input logic [3:0] lidx);
    for (int k = 0; k < 2; k++)
      check({tag, k == 0 ? "_s_lookup" : "_u_lookup"}, 32'(o_lt[k]), 32'(m_bht[k][lidx] >= 2));
  endtask

  // Called at posedge+1; drives one ID-stage instruction through one clock edge.
  task automatic step(input logic v, input logic s, input logic [5:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] pidx, input logic pr, input logic [3:0] lidx);
    logic [25:0] hi;
    hi = 26'($urandom);
    valid_in = v; stall = s; IR = {op, 26'($urandom)}; In1 = a; In2 = b;
    pc_id = {hi, pidx, 2'b00}; pred_taken_in = pr;
    hi = 26'($urandom);
    lookup_pc = {hi, lidx, 2'b00};
    #1 check_lookup("pre_edge", lidx);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!s) begin
        bit br, t;
        br = v && (op >= 6'h08) && (op <= 6'h0D);
        t  = br && ref_taken(k == 0, op, a, b);
        m_by[k] = t; m_ib[k] = br; m_mp[k] = br && (t != pr);
        if (br) begin
          m_bht[k][pidx] = t ? ((m_bht[k][pidx] < 3) ? m_bht[k][pidx] + 1 : 3)
                             : ((m_bht[k][pidx] > 0) ? m_bht[k][pidx] - 1 : 0);
          m_bc[k] = (m_bc[k] < CMAX) ? m_bc[k] + 1 : CMAX;
          if (m_mp[k] != 0) m_mc[k] = (m_mc[k] < CMAX) ? m_mc[k] + 1 : CMAX;
        end
      end
    end
    #1;
    check_regs("post_edge");
    check_lookup("post_edge", lidx);
  endtask

  task automatic check_all_lookups_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      lookup_pc = 32'(i) << 2;
      #1;
      check({tag, "_s"}, 32'(o_lt[0]), 32'd0);
      check({tag, "_u"}, 32'(o_lt[1]), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] a, b;
    logic [5:0]  op;
    rst = 1'b1; valid_in = 0; stall = 0; IR = 0; In1 = 0; In2 = 0;
    pc_id = 0; pred_taken_in = 0; lookup_pc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_regs("reset");
    check_all_lookups_zero("reset_lookup");
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // beq equal operands, predicted not-taken
    step(1, 0, 6'h08, 32'h1234, 32'h1234, 4'd3, 0, 4'd3);
    check("beq_by", 32'(o_by[0]), 32'd1);
    check("beq_mp", 32'(o_mp[0]), 32'd1);
    check("beq_bht", 32'(o_lt[0]), 32'd1);

    // blt -1 vs 1: differs by signedness
    step(1, 0, 6'h0D, 32'hFFFF_FFFF, 32'h1, 4'd5, 0, 4'd5);
    check("blt_signed", 32'(o_by[0]), 32'd1);
    check("blt_unsigned", 32'(o_by[1]), 32'd0);

    // BHT saturation up then down at one index
    repeat (4) step(1, 0, 6'h0B, 32'd5, 32'd3, 4'd7, 1, 4'd7);
    check("sat_up", 32'(o_lt[0]), 32'd1);
    repeat (3) step(1, 0, 6'h0B, 32'd3, 32'd5, 4'd7, 1, 4'd7);
    check("sat_down", 32'(o_lt[0]), 32'd0);

    // stalled taken branch changes nothing; then collision at same index
    step(1, 1, 6'h08, 32'd9, 32'd9, 4'd7, 0, 4'd7);
    step(1, 0, 6'h08, 32'd9, 32'd9, 4'd9, 0, 4'd9);
    step(1, 0, 6'h08, 32'd9, 32'd9, 4'd9, 0, 4'd9);

    // non-branch opcodes after a taken branch
    step(1, 0, 6'h00, 32'd1, 32'd1, 4'd9, 0, 4'd9);
    step(1, 0, 6'h23, 32'd1, 32'd1, 4'd9, 1, 4'd9);
    step(0, 0, 6'h08, 32'd1, 32'd1, 4'd9, 0, 4'd9);

    // randomized traffic, narrow index range to force collisions
    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'h23 : 6'($urandom_range(6, 15));
      a  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 7));
      b  = $urandom_range(0, 2) == 0 ? a : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 7)));
      step($urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0, op, a, b,
           4'($urandom_range(0, 3)), 1'($urandom), 4'($urandom_range(0, 3)));
    end

    // drive the counter into saturation
    for (int n = 0; n < 40; n++) step(1, 0, 6'h08, 32'd4, 32'd4, 4'($urandom), 1'($urandom), 4'($urandom));
    check("cnt_saturated", 32'(o_bc[0]), 32'(CMAX));
    step(1, 0, 6'h09, 32'd1, 32'd2, 4'd1, 0, 4'd1);
    check("cnt_stays", 32'(o_bc[0]), 32'(CMAX));

    // asynchronous reset mid-cycle while stalled
    step(1, 0, 6'h08, 32'd4, 32'd4, 4'd2, 0, 4'd2);
    stall = 1'b1;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_regs("async_reset");
    check_all_lookups_zero("async_reset_lookup");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    step(1, 0, 6'h0C, 32'hFFFF_FFFE, 32'd3, 4'd2, 1, 4'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
